disparity_frame_writer: RTL and testbench
=========================================

// Module: disparity_frame_writer
// PURPOSE
//  Downstream of the stereo SSD disparity engine. Captures the pixel pair
//  strobed by HSYNC into a full-frame buffer: even pixel on DATA_0, odd on
//  DATA_1, scaled disparity 0..250. Once WIDTH*HEIGHT pixels are stored, it
//  replays them row-major, one per cycle, on a valid/ready stream to the
//  hex/BMP writer or display path.
// PARAMETERS
//  WIDTH    320  pixels per row; must be even
//  HEIGHT   240  rows per frame
//  DATA_W   8    bits per disparity pixel
// PORTS
//  HCLK         in   1       single clock; all logic on posedge
//  HRESETn      in   1       asynchronous, active-low reset
//  VSYNC        in   1       frame-start level from the disparity stage
//  HSYNC        in   1       one-cycle strobe; DATA_0/DATA_1 valid this cycle
//  DATA_0       in   DATA_W  disparity of even column (col)
//  DATA_1       in   DATA_W  disparity of odd column (col+1)
//  rd_ready     in   1       downstream accepts rd_data this cycle
//  rd_valid     out  1       rd_data holds a valid pixel
//  rd_data      out  DATA_W  pixel, row-major order
//  rd_last      out  1       high with the final pixel of the frame
//  frame_done   out  1       one-cycle pulse after the last handshake
//  drop_err     out  1       sticky; an HSYNC strobe arrived outside CAPTURE
// BEHAVIOUR
//  Reset: state=IDLE, wr_col=0, wr_row=0, rd_addr=0, and all outputs at 0.
//  FSM: IDLE -> CAPTURE on VSYNC=1.
//       CAPTURE -> READOUT on the cycle the pair at (HEIGHT-1, WIDTH-2) is written.
//       READOUT -> DONE on the rd_valid&&rd_ready handshake with rd_last=1.
//       DONE -> IDLE after one cycle; frame_done=1 only in DONE.
//  CAPTURE: each HSYNC=1 writes DATA_0 to bank0[a] and DATA_1 to bank1[a],
//    where a = wr_row*(WIDTH/2) + wr_col/2. Both writes land in the same cycle.
//    wr_col then advances by 2. At wr_col==WIDTH-2 it wraps to 0 and wr_row
//    increments. Back-to-back HSYNC strobes, one every cycle, are supported.
//  VSYNC=1 during CAPTURE with a partial frame clears wr_col/wr_row and
//    restarts capture. Already-written data is overwritten, not cleared.
//  VSYNC during READOUT or DONE is ignored; the frame is not restarted.
//  HSYNC=1 in IDLE, READOUT or DONE: data is discarded and drop_err sets.
//    drop_err clears only on reset.
//  READOUT: pixel index p runs 0..WIDTH*HEIGHT-1. Even p reads bank0[p/2];
//    odd p reads bank1[p/2].
//    Memory read is registered. rd_valid first rises 2 cycles after
//    entering READOUT.
//    Once the pipeline is full, one pixel transfers per cycle while rd_ready=1.
//    While rd_valid=1 and rd_ready=0, rd_data and rd_last hold stable.
//    A 2-entry skid buffer absorbs the in-flight read, so no pixel is lost
//    or duplicated.
//    rd_valid must never drop without a handshake.
//  Widths: wr_row is clog2(HEIGHT); wr_col is clog2(WIDTH).
//    The bank address is clog2(WIDTH*HEIGHT/2), i.e. 16 bits at the defaults.
//    Address arithmetic never exceeds WIDTH*HEIGHT/2-1.
//  Async reset asserted mid-CAPTURE or mid-READOUT: return to reset state
//    immediately. Buffer contents are undefined afterwards and are not read
//    until the next full capture.
// STRUCTURE
//  disp_pkg: state encoding (ST_IDLE, ST_CAPTURE, ST_READOUT, ST_DONE),
//    the DATA_W default, and a clog2 helper function.
//  Sub-module disp_bank_ram: single-port synchronous RAM with one write or
//    one read per cycle and a registered read.
//    It is instantiated twice, as bank0 and bank1.
//  Everything else is in the top: FSM, write counters, read address,
//    skid buffer, drop_err.
// TESTING
//  1) Reset, VSYNC 1 cycle, then 38400 back-to-back HSYNC strobes with
//     DATA_0=p%251, DATA_1=(p+1)%251. Hold rd_ready=1.
//     -> 76800 pixels in row-major order, each equal to its index %251.
//     rd_last on pixel 76799. frame_done 1 cycle after that.
//  2) Same capture; during readout drive rd_ready as a random pattern with
//     30% duty. -> Identical sequence, no drops or duplicates, and rd_data
//     stable on every stalled cycle.
//  3) Write 100 pairs, pulse VSYNC, then a full frame of 0xAA/0x55.
//     -> Readout is alternating 0xAA,0x55 for all 76800 pixels.
//  4) HSYNC strobe while IDLE, then a normal frame.
//     -> drop_err=1 and stays 1. The frame reads out correctly.
//  5) Assert HRESETn=0 at readout pixel 500.
//     -> All outputs 0 and state IDLE on the next edge. The next VSYNC plus
//     a full frame reads out correctly.
//  6) WIDTH=4, HEIGHT=2 build with 4 strobes.
//     -> Exactly 8 pixels. rd_last only on the 8th. The row wrap is exercised.

Source files
------------

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_pkg
// Brief    : Shared types and helpers for the disparity frame writer: FSM
//            state encoding, default pixel width and a ceil-log2 helper.
// Revision : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // Default disparity pixel width (scaled disparity 0..250 fits in 8 bits)
    localparam int DISP_DATA_W = 8;

    // Frame writer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READOUT = 2'd2,
        ST_DONE    = 2'd3
    } disp_state_t;

    // Ceil-log2, never below 1 so that derived vectors always have a bit
    function automatic int disp_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : disp_bank_ram
// Brief    : Single-port synchronous RAM, one write or one read per cycle,
//            read data registered. One instance per pixel bank.
// Revision : 1.0 - initial release
// ============================================================================
module disp_bank_ram #(
    parameter int DEPTH  = 38400,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write takes priority; a read updates the output register only when enabled
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/disparity_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : disparity_frame_writer
// Brief    : Captures HSYNC-strobed disparity pixel pairs into a two-bank
//            frame buffer, then replays the frame row-major on a
//            valid/ready stream through a 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module disparity_frame_writer
    import disp_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int DATA_W = DISP_DATA_W
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              VSYNC,
    input  logic              HSYNC,
    input  logic [DATA_W-1:0] DATA_0,
    input  logic [DATA_W-1:0] DATA_1,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              frame_done,
    output logic              drop_err
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int c_PIXELS = WIDTH * HEIGHT;
    localparam int c_PAIRS  = c_PIXELS / 2;
    localparam int c_ADDR_W = disp_clog2(c_PAIRS);
    localparam int c_PIX_W  = c_ADDR_W + 1;
    localparam int c_COL_W  = disp_clog2(WIDTH);
    localparam int c_ROW_W  = disp_clog2(HEIGHT);

    localparam logic [c_COL_W-1:0]  c_LAST_COL = c_COL_W'(WIDTH - 2);
    localparam logic [c_ROW_W-1:0]  c_LAST_ROW = c_ROW_W'(HEIGHT - 1);
    localparam logic [c_PIX_W-1:0]  c_LAST_PIX = c_PIX_W'(c_PIXELS - 1);

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    disp_state_t r_state;
    disp_state_t w_state_next;

    logic [c_COL_W-1:0]  r_wr_col;
    logic [c_ROW_W-1:0]  r_wr_row;
    logic [c_ADDR_W-1:0] r_wr_addr;

    logic [c_PIX_W-1:0]  r_rd_addr;
    logic                r_issue_done;
    logic                r_pend;
    logic                r_pend_bank;
    logic                r_pend_last;

    logic [DATA_W-1:0]   r_buf_data [2];
    logic                r_buf_last [2];
    logic                r_head;
    logic [1:0]          r_count;

    logic                r_drop_err;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                w_capture;
    logic                w_readout;
    logic                w_wr_en;
    logic                w_frame_end;
    logic                w_pop;
    logic [2:0]          w_occ;
    logic                w_room;
    logic                w_issue;
    logic                w_slot;
    logic [c_ADDR_W-1:0] w_ram_addr;
    logic                w_ram_en;
    logic [DATA_W-1:0]   w_q0;
    logic [DATA_W-1:0]   w_q1;
    logic [DATA_W-1:0]   w_ram_q;

    assign w_capture   = (r_state == ST_CAPTURE);
    assign w_readout   = (r_state == ST_READOUT);

    // A VSYNC restart wins over a coincident strobe; that strobe is not stored
    assign w_wr_en     = w_capture && HSYNC && !VSYNC;
    assign w_frame_end = w_wr_en && (r_wr_col == c_LAST_COL) && (r_wr_row == c_LAST_ROW);

    assign w_pop       = rd_valid && rd_ready;

    // Skid occupancy after this edge must stay within 2 entries, counting
    // the read whose data sits in the RAM output register right now
    assign w_occ       = {1'b0, r_count} + {2'b00, r_pend};
    assign w_room      = (w_occ < 3'd2) || (w_pop && (w_occ == 3'd2));
    assign w_issue     = w_readout && !r_issue_done && w_room;

    // Next free skid slot; only used while fewer than 2 entries are held
    assign w_slot      = r_head ^ r_count[0];

    assign w_ram_addr  = w_readout ? r_rd_addr[c_PIX_W-1:1] : r_wr_addr;
    assign w_ram_en    = w_wr_en || w_issue;
    assign w_ram_q     = r_pend_bank ? w_q1 : w_q0;

    // ------------------------------------------------------------------
    // Pixel banks: even columns in bank0, odd columns in bank1
    // ------------------------------------------------------------------
    disp_bank_ram #(
        .DEPTH  (c_PAIRS),
        .ADDR_W (c_ADDR_W),
        .DATA_W (DATA_W)
    ) u_bank0 (
        .clk   (HCLK),
        .en    (w_ram_en),
        .we    (w_wr_en),
        .addr  (w_ram_addr),
        .wdata (DATA_0),
        .rdata (w_q0)
    );

    disp_bank_ram #(
        .DEPTH  (c_PAIRS),
        .ADDR_W (c_ADDR_W),
        .DATA_W (DATA_W)
    ) u_bank1 (
        .clk   (HCLK),
        .en    (w_ram_en),
        .we    (w_wr_en),
        .addr  (w_ram_addr),
        .wdata (DATA_1),
        .rdata (w_q1)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; VSYNC outside IDLE/CAPTURE is deliberately ignored
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (VSYNC)                  w_state_next = ST_CAPTURE;
            ST_CAPTURE: if (w_frame_end)            w_state_next = ST_READOUT;
            ST_READOUT: if (w_pop && rd_last)       w_state_next = ST_DONE;
            ST_DONE:                                w_state_next = ST_IDLE;
            default:                                w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write position: column pair, row and linear pair address
    // ------------------------------------------------------------------
    // Counters hold at origin outside CAPTURE and restart on VSYNC mid-frame
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr_col  <= '0;
            r_wr_row  <= '0;
            r_wr_addr <= '0;
        end else if (!w_capture || VSYNC) begin
            r_wr_col  <= '0;
            r_wr_row  <= '0;
            r_wr_addr <= '0;
        end else if (w_wr_en) begin
            if (r_wr_col == c_LAST_COL) begin
                r_wr_col <= '0;
                r_wr_row <= (r_wr_row == c_LAST_ROW) ? '0 : r_wr_row + c_ROW_W'(1);
            end else begin
                r_wr_col <= r_wr_col + c_COL_W'(2);
            end
            r_wr_addr <= w_frame_end ? '0 : r_wr_addr + c_ADDR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Read issue: pixel index and RAM-output tracking
    // ------------------------------------------------------------------
    // Issues one pixel read per cycle while the skid buffer has credit
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rd_addr    <= '0;
            r_issue_done <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_bank  <= 1'b0;
            r_pend_last  <= 1'b0;
        end else if (!w_readout) begin
            r_rd_addr    <= '0;
            r_issue_done <= 1'b0;
            r_pend       <= 1'b0;
        end else begin
            r_pend <= w_issue;
            if (w_issue) begin
                r_pend_bank <= r_rd_addr[0];
                r_pend_last <= (r_rd_addr == c_LAST_PIX);
                if (r_rd_addr == c_LAST_PIX) begin
                    r_issue_done <= 1'b1;
                end else begin
                    r_rd_addr <= r_rd_addr + c_PIX_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // 2-entry skid buffer feeding the output stream
    // ------------------------------------------------------------------
    // Captures each RAM read result and pops on handshake; empties outside READOUT
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_last[i] <= 1'b0;
            end
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else if (!w_readout) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (r_pend) begin
                r_buf_data[w_slot] <= w_ram_q;
                r_buf_last[w_slot] <= r_pend_last;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            unique case ({r_pend, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky drop error
    // ------------------------------------------------------------------
    // Any strobe outside CAPTURE is discarded and flagged until reset
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_drop_err <= 1'b0;
        end else if (HSYNC && !w_capture) begin
            r_drop_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_valid   = (r_count != 2'd0);
    assign rd_data    = r_buf_data[r_head];
    assign rd_last    = rd_valid && r_buf_last[r_head];
    assign frame_done = (r_state == ST_DONE);
    assign drop_err   = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_disparity_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_disparity_frame_writer
// Brief    : Self-checking bench for disparity_frame_writer: a reduced-size
//            frame instance plus a 4x2 instance for the minimal-frame case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disparity_frame_writer;
    import disp_pkg::*;

    localparam int c_W = 32;
    localparam int c_H = 16;
    localparam int c_N = c_W * c_H;
    localparam int c_PAIRS = c_N / 2;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       VSYNC = 1'b0;
    logic       HSYNC = 1'b0;
    logic [7:0] DATA_0 = 8'd0;
    logic [7:0] DATA_1 = 8'd0;
    logic       rd_ready = 1'b0;
    logic       rd_valid, rd_last, frame_done, drop_err;
    logic [7:0] rd_data;

    logic       vs_b = 1'b0;
    logic       hs_b = 1'b0;
    logic [7:0] d0_b = 8'd0;
    logic [7:0] d1_b = 8'd0;
    logic       rdy_b = 1'b0;
    logic       valid_b, last_b, done_b, drop_b;
    logic [7:0] data_b;

    always #5 HCLK = ~HCLK;

    disparity_frame_writer #(.WIDTH(c_W), .HEIGHT(c_H), .DATA_W(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC),
        .DATA_0(DATA_0), .DATA_1(DATA_1), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .frame_done(frame_done), .drop_err(drop_err)
    );

    disparity_frame_writer #(.WIDTH(4), .HEIGHT(2), .DATA_W(8)) dut_small (
        .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(vs_b), .HSYNC(hs_b),
        .DATA_0(d0_b), .DATA_1(d1_b), .rd_ready(rdy_b),
        .rd_valid(valid_b), .rd_data(data_b), .rd_last(last_b),
        .frame_done(done_b), .drop_err(drop_b)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         got_last_q[$];
    int         stall_bad;
    int         done_gap;
    int         first_valid;
    bit         tmo;

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------
    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        VSYNC = 1'b0; HSYNC = 1'b0; rd_ready = 1'b0;
        vs_b = 1'b0; hs_b = 1'b0; rdy_b = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    // Optional VSYNC cycle, then npairs back-to-back strobes; expected
    // pixels are pushed to the scoreboard as they are driven
    task automatic capture(input int mode, input int npairs, input bit vs);
        @(negedge HCLK);
        VSYNC = vs;
        for (int i = 0; i < npairs; i++) begin
            @(negedge HCLK);
            VSYNC = 1'b0;
            HSYNC = 1'b1;
            if (mode == 0) begin
                DATA_0 = 8'((2 * i) % 251);
                DATA_1 = 8'((2 * i + 1) % 251);
            end else begin
                DATA_0 = 8'hAA;
                DATA_1 = 8'h55;
            end
            exp_q.push_back(DATA_0);
            exp_q.push_back(DATA_1);
        end
        @(negedge HCLK);
        HSYNC = 1'b0;
        VSYNC = 1'b0;
    endtask

    // Collects handshaken pixels with rd_ready at duty percent
    task automatic drain(input int duty, input int limit_px);
        int         cyc;
        bit         stalled;
        bit         saw_last;
        logic [7:0] held_d;
        logic       held_l;
        cyc = 0; stalled = 0; saw_last = 0; held_d = 8'd0; held_l = 1'b0;
        got_q.delete(); got_last_q.delete();
        stall_bad = 0; tmo = 0; done_gap = -1; first_valid = -1;
        forever begin
            @(negedge HCLK);
            cyc++;
            if (saw_last) begin
                done_gap = frame_done ? 1 : 0;
                break;
            end
            if (cyc > 20000) begin
                tmo = 1;
                break;
            end
            if (first_valid < 0 && rd_valid) first_valid = cyc;
            if (stalled && (rd_valid !== 1'b1 || rd_data !== held_d || rd_last !== held_l))
                stall_bad++;
            if (got_q.size() >= limit_px) break;
            rd_ready = ($urandom_range(99) < duty);
            if (rd_valid && rd_ready) begin
                got_q.push_back(rd_data);
                got_last_q.push_back(rd_last);
                saw_last = rd_last;
                stalled = 0;
            end else begin
                stalled = rd_valid;
                held_d = rd_data;
                held_l = rd_last;
            end
        end
        rd_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({rd_valid, rd_last, frame_done, drop_err} !== 4'b0000 || rd_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b l=%b d=%b e=%b data=%0h expected all 0",
                     rd_valid, rd_last, frame_done, drop_err, rd_data);
        end
        checks++;
        if (dut.r_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d expected %0d", dut.r_state, ST_IDLE);
        end
        checks++;
        if ({valid_b, last_b, done_b, drop_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_small got %b expected 0000", {valid_b, last_b, done_b, drop_b});
        end
    endtask

    task automatic test_full_frame();
        logic [7:0] e;
        do_reset();
        capture(0, c_PAIRS, 1'b1);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_valid_early got %b expected 0", rd_valid);
        end
        drain(100, c_N + 4);
        checks++;
        if (tmo || got_q.size() != c_N) begin
            errors++;
            $display("FAIL t1_count got %0d expected %0d (timeout=%0d)", got_q.size(), c_N, tmo);
        end
        checks++;
        if (first_valid != 2) begin
            errors++;
            $display("FAIL t1_latency got %0d expected 2", first_valid);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got_q[i] !== e || got_last_q[i] !== (i == c_N - 1)) begin
                errors++;
                $display("FAIL t1_pixel %0d got %0h/%0b expected %0h/%0b",
                         i, got_q[i], got_last_q[i], e, (i == c_N - 1));
            end
        end
        checks++;
        if (done_gap != 1) begin
            errors++;
            $display("FAIL t1_frame_done got %0d expected 1", done_gap);
        end
        @(negedge HCLK);
        checks++;
        if (frame_done !== 1'b0 || dut.r_state !== ST_IDLE) begin
            errors++;
            $display("FAIL t1_done_pulse got done=%b state=%0d expected 0/IDLE", frame_done, dut.r_state);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        do_reset();
        capture(0, c_PAIRS, 1'b1);
        drain(30, c_N + 4);
        checks++;
        if (tmo || got_q.size() != c_N) begin
            errors++;
            $display("FAIL t2_count got %0d expected %0d (timeout=%0d)", got_q.size(), c_N, tmo);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got_q[i] !== e || got_last_q[i] !== (i == c_N - 1)) begin
                errors++;
                $display("FAIL t2_pixel %0d got %0h/%0b expected %0h/%0b",
                         i, got_q[i], got_last_q[i], e, (i == c_N - 1));
            end
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL t2_stall_stable got %0d unstable cycles expected 0", stall_bad);
        end
        checks++;
        if (done_gap != 1) begin
            errors++;
            $display("FAIL t2_frame_done got %0d expected 1", done_gap);
        end
    endtask

    task automatic test_restart();
        logic [7:0] e;
        do_reset();
        capture(0, 100, 1'b1);
        exp_q.delete();
        capture(1, c_PAIRS, 1'b1);
        drain(100, c_N + 4);
        checks++;
        if (tmo || got_q.size() != c_N) begin
            errors++;
            $display("FAIL t3_count got %0d expected %0d (timeout=%0d)", got_q.size(), c_N, tmo);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got_q[i] !== e) begin
                errors++;
                $display("FAIL t3_pixel %0d got %0h expected %0h", i, got_q[i], e);
            end
        end
    endtask

    task automatic test_drop_err();
        logic [7:0] e;
        do_reset();
        @(negedge HCLK);
        HSYNC = 1'b1; DATA_0 = 8'hEE; DATA_1 = 8'hEE;
        @(negedge HCLK);
        HSYNC = 1'b0;
        checks++;
        if (drop_err !== 1'b1 || dut.r_state !== ST_IDLE) begin
            errors++;
            $display("FAIL t4_drop_set got err=%b state=%0d expected 1/IDLE", drop_err, dut.r_state);
        end
        capture(0, c_PAIRS, 1'b1);
        drain(100, c_N + 4);
        checks++;
        if (tmo || got_q.size() != c_N) begin
            errors++;
            $display("FAIL t4_count got %0d expected %0d (timeout=%0d)", got_q.size(), c_N, tmo);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got_q[i] !== e) begin
                errors++;
                $display("FAIL t4_pixel %0d got %0h expected %0h", i, got_q[i], e);
            end
        end
        checks++;
        if (drop_err !== 1'b1) begin
            errors++;
            $display("FAIL t4_drop_sticky got %b expected 1", drop_err);
        end
    endtask

    task automatic test_reset_mid_readout();
        logic [7:0] e;
        do_reset();
        capture(0, c_PAIRS, 1'b1);
        drain(100, 500);
        for (int i = 0; i < got_q.size(); i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got_q[i] !== e) begin
                errors++;
                $display("FAIL t5_pre_pixel %0d got %0h expected %0h", i, got_q[i], e);
            end
        end
        HRESETn = 1'b0;
        #1;
        checks++;
        if ({rd_valid, rd_last, frame_done, drop_err} !== 4'b0000 || rd_data !== 8'd0 ||
            dut.r_state !== ST_IDLE) begin
            errors++;
            $display("FAIL t5_async_reset got v=%b l=%b d=%b e=%b data=%0h state=%0d expected 0/IDLE",
                     rd_valid, rd_last, frame_done, drop_err, rd_data, dut.r_state);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        exp_q.delete();
        capture(1, c_PAIRS, 1'b1);
        drain(100, c_N + 4);
        checks++;
        if (tmo || got_q.size() != c_N) begin
            errors++;
            $display("FAIL t5_count got %0d expected %0d (timeout=%0d)", got_q.size(), c_N, tmo);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got_q[i] !== e || got_last_q[i] !== (i == c_N - 1)) begin
                errors++;
                $display("FAIL t5_pixel %0d got %0h/%0b expected %0h/%0b",
                         i, got_q[i], got_last_q[i], e, (i == c_N - 1));
            end
        end
    endtask

    task automatic test_small_frame();
        logic [7:0] sb_q[$];
        logic [7:0] gd[$];
        bit         gl[$];
        int         done_cnt;
        logic [7:0] e;
        do_reset();
        @(negedge HCLK);
        vs_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            vs_b = 1'b0;
            hs_b = 1'b1;
            d0_b = 8'(10 + 2 * i);
            d1_b = 8'(11 + 2 * i);
            sb_q.push_back(d0_b);
            sb_q.push_back(d1_b);
        end
        @(negedge HCLK);
        hs_b = 1'b0;
        rdy_b = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge HCLK);
            if (done_b) done_cnt++;
            if (valid_b && rdy_b) begin
                gd.push_back(data_b);
                gl.push_back(last_b);
            end
        end
        rdy_b = 1'b0;
        checks++;
        if (gd.size() != 8) begin
            errors++;
            $display("FAIL t6_count got %0d expected 8", gd.size());
        end
        for (int i = 0; i < gd.size(); i++) begin
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            checks++;
            if (gd[i] !== e || gl[i] !== (i == 7)) begin
                errors++;
                $display("FAIL t6_pixel %0d got %0h/%0b expected %0h/%0b", i, gd[i], gl[i], e, (i == 7));
            end
        end
        checks++;
        if (done_cnt != 1 || drop_b !== 1'b0) begin
            errors++;
            $display("FAIL t6_done got pulses=%0d drop=%b expected 1/0", done_cnt, drop_b);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_restart();
        test_drop_err();
        test_reset_mid_readout();
        test_small_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
